// File: rtl/rom_port_arbiter.sv
// Shares one combinational ROM port between instruction fetch and data reads.
// Round-robin grant, registered address stage, registered response stage.
module rom_port_arbiter #(
    parameter int PC_W = 30
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [PC_W-1:0] if_addr,
    output logic            if_gnt,
    input  logic            if_flush,
    output logic            if_rvalid,
    output logic [15:0]     if_rdata,
    output logic            if_err,
    input  logic            dr_req,
    input  logic [PC_W-1:0] dr_addr,
    output logic            dr_gnt,
    output logic            dr_rvalid,
    output logic [15:0]     dr_rdata,
    output logic            dr_err,
    output logic [PC_W-1:0] rom_pc,
    input  logic [15:0]     rom_instruction
);

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_DR = 1'b1
    } owner_t;

    owner_t          last_owner;
    owner_t          s1_owner;
    logic            s1_valid;
    logic            s1_err;
    logic            s1_live;
    logic            any_gnt;
    logic [PC_W-1:0] gnt_addr;
    logic [15:0]     s1_data;

    // Grants are held low while reset is asserted so every output reads 0.
    always_comb begin
        if_gnt = 1'b0;
        dr_gnt = 1'b0;
        if (rst_n) begin
            if (if_req && dr_req) begin
                if (last_owner == OWNER_DR) begin
                    if_gnt = 1'b1;
                end else begin
                    dr_gnt = 1'b1;
                end
            end else if (if_req) begin
                if_gnt = 1'b1;
            end else if (dr_req) begin
                dr_gnt = 1'b1;
            end
        end
    end

    assign any_gnt  = if_gnt | dr_gnt;
    assign gnt_addr = dr_gnt ? dr_addr : if_addr;

    // A flush kills only the fetch sitting in stage 1, never the one granted now.
    assign s1_live = s1_valid && !(if_flush && (s1_owner == OWNER_IF));
    assign s1_data = s1_err ? 16'h0000 : rom_instruction;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= OWNER_DR;
        end else if (if_gnt) begin
            last_owner <= OWNER_IF;
        end else if (dr_gnt) begin
            last_owner <= OWNER_DR;
        end
    end

    // rom_pc only moves on a grant so the ROM does not toggle while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_owner <= OWNER_IF;
            s1_err   <= 1'b0;
            rom_pc   <= '0;
        end else begin
            s1_valid <= any_gnt;
            if (any_gnt) begin
                s1_owner <= dr_gnt ? OWNER_DR : OWNER_IF;
                s1_err   <= gnt_addr[0];
                rom_pc   <= gnt_addr;
            end
        end
    end

    // Response stage: the non-owner keeps its last data word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= 16'h0000;
            dr_rvalid <= 1'b0;
            dr_err    <= 1'b0;
            dr_rdata  <= 16'h0000;
        end else begin
            if_rvalid <= s1_live && (s1_owner == OWNER_IF);
            if_err    <= s1_live && (s1_owner == OWNER_IF) && s1_err;
            dr_rvalid <= s1_live && (s1_owner == OWNER_DR);
            dr_err    <= s1_live && (s1_owner == OWNER_DR) && s1_err;
            if (s1_live && (s1_owner == OWNER_IF)) begin
                if_rdata <= s1_data;
            end
            if (s1_live && (s1_owner == OWNER_DR)) begin
                dr_rdata <= s1_data;
            end
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed self-checking bench for rom_port_arbiter with a small ROM lookup table.
module tb_rom_port_arbiter;

    localparam int PC_W = 30;

    logic            clk;
    logic            rst_n;
    logic            if_req;
    logic [PC_W-1:0] if_addr;
    logic            if_gnt;
    logic            if_flush;
    logic            if_rvalid;
    logic [15:0]     if_rdata;
    logic            if_err;
    logic            dr_req;
    logic [PC_W-1:0] dr_addr;
    logic            dr_gnt;
    logic            dr_rvalid;
    logic [15:0]     dr_rdata;
    logic            dr_err;
    logic [PC_W-1:0] rom_pc;
    logic [15:0]     rom_instruction;

    int checks;
    int errors;

    rom_port_arbiter #(.PC_W(PC_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_req          (if_req),
        .if_addr         (if_addr),
        .if_gnt          (if_gnt),
        .if_flush        (if_flush),
        .if_rvalid       (if_rvalid),
        .if_rdata        (if_rdata),
        .if_err          (if_err),
        .dr_req          (dr_req),
        .dr_addr         (dr_addr),
        .dr_gnt          (dr_gnt),
        .dr_rvalid       (dr_rvalid),
        .dr_rdata        (dr_rdata),
        .dr_err          (dr_err),
        .rom_pc          (rom_pc),
        .rom_instruction (rom_instruction)
    );

    function automatic logic [15:0] rom_model(input logic [PC_W-1:0] a);
        case (a)
            30'h0:   return 16'h5CCD;
            30'h2:   return 16'h1234;
            30'h3:   return 16'h7777;
            30'h4:   return 16'h9200;
            30'h8:   return 16'h3C3C;
            30'hA:   return 16'hB000;
            30'hC:   return 16'hB80E;
            default: return 16'hDEAD;
        endcase
    endfunction

    always_comb rom_instruction = rom_model(rom_pc);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after the edge that releases reset.
    task automatic apply_reset;
        rst_n    = 1'b0;
        if_req   = 1'b0;
        dr_req   = 1'b0;
        if_flush = 1'b0;
        if_addr  = '0;
        dr_addr  = '0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [67:0] outs;
        rst_n    = 1'b0;
        if_req   = 1'b1;
        dr_req   = 1'b1;
        if_flush = 1'b0;
        if_addr  = 30'h4;
        dr_addr  = 30'hA;
        #1;
        checks++;
        if ({if_gnt, dr_gnt} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_gnt: got %b expected 00", {if_gnt, dr_gnt});
        end
        next_cycle();
        outs = {if_gnt, dr_gnt, if_rvalid, if_err, dr_rvalid, dr_err, if_rdata, dr_rdata, rom_pc};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({if_gnt, dr_gnt} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL first_contention: got %b expected 10", {if_gnt, dr_gnt});
        end
        if_req = 1'b0;
        dr_req = 1'b0;
        repeat (3) next_cycle();
    endtask

    task automatic test_single_fetch;
        apply_reset();
        if_req  = 1'b1;
        if_addr = 30'h0;
        #1;
        checks++;
        if ({if_gnt, dr_gnt} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL single_gnt: got %b expected 10", {if_gnt, dr_gnt});
        end
        next_cycle();
        if_req = 1'b0;
        checks++;
        if (rom_pc !== 30'h0 || if_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_stage1: got pc=%h rv=%b expected pc=0 rv=0", rom_pc, if_rvalid);
        end
        next_cycle();
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 16'h5CCD || if_err !== 1'b0 || dr_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_resp: got rv=%b d=%h e=%b drv=%b expected 1 5ccd 0 0",
                     if_rvalid, if_rdata, if_err, dr_rvalid);
        end
        next_cycle();
        checks++;
        if (if_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_pulse: got %b expected 0", if_rvalid);
        end
    endtask

    task automatic test_back_to_back;
        logic exp_f;
        logic exp_rf;
        apply_reset();
        if_req  = 1'b1;
        dr_req  = 1'b1;
        if_addr = 30'h4;
        dr_addr = 30'hA;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_f = (k % 2 == 0);
            checks++;
            if (if_gnt !== exp_f || dr_gnt !== !exp_f) begin
                errors++;
                $display("[TB] FAIL b2b_gnt[%0d]: got %b%b expected %b%b", k, if_gnt, dr_gnt, exp_f, !exp_f);
            end
            if (k >= 1) begin
                checks++;
                if (rom_pc !== (((k - 1) % 2 == 0) ? 30'h4 : 30'hA)) begin
                    errors++;
                    $display("[TB] FAIL b2b_pc[%0d]: got %h", k, rom_pc);
                end
            end
            if (k >= 2) begin
                exp_rf = ((k - 2) % 2 == 0);
                checks++;
                if (if_rvalid !== exp_rf || dr_rvalid !== !exp_rf ||
                    (exp_rf && if_rdata !== 16'h9200) || (!exp_rf && dr_rdata !== 16'hB000)) begin
                    errors++;
                    $display("[TB] FAIL b2b_resp[%0d]: got rv=%b%b if=%h dr=%h expected rv=%b%b",
                             k, if_rvalid, dr_rvalid, if_rdata, dr_rdata, exp_rf, !exp_rf);
                end
            end else begin
                checks++;
                if (if_rvalid !== 1'b0 || dr_rvalid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL b2b_early[%0d]: got %b%b expected 00", k, if_rvalid, dr_rvalid);
                end
            end
            next_cycle();
        end
        if_req = 1'b0;
        dr_req = 1'b0;
        repeat (2) next_cycle();
    endtask

    task automatic test_misaligned;
        apply_reset();
        dr_req  = 1'b1;
        dr_addr = 30'h3;
        #1;
        checks++;
        if ({if_gnt, dr_gnt} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL mis_gnt: got %b expected 01", {if_gnt, dr_gnt});
        end
        next_cycle();
        dr_req = 1'b0;
        next_cycle();
        checks++;
        if (dr_rvalid !== 1'b1 || dr_err !== 1'b1 || dr_rdata !== 16'h0000 || if_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mis_resp: got rv=%b e=%b d=%h irv=%b expected 1 1 0000 0",
                     dr_rvalid, dr_err, dr_rdata, if_rvalid);
        end
        next_cycle();
        checks++;
        if (dr_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mis_err_pulse: got %b expected 0", dr_err);
        end
    endtask

    task automatic test_flush_new_target;
        apply_reset();
        if_req  = 1'b1;
        if_addr = 30'h2;
        next_cycle();
        if_flush = 1'b1;
        if_addr  = 30'hC;
        #1;
        checks++;
        if (if_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_new_gnt: got %b expected 1", if_gnt);
        end
        next_cycle();
        if_flush = 1'b0;
        if_req   = 1'b0;
        checks++;
        if (if_rvalid !== 1'b0 || if_rdata !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL flush_killed: got rv=%b d=%h expected 0 0000", if_rvalid, if_rdata);
        end
        next_cycle();
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 16'hB80E || if_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_target: got rv=%b d=%h e=%b expected 1 b80e 0", if_rvalid, if_rdata, if_err);
        end
        next_cycle();
        checks++;
        if (if_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_target_pulse: got %b expected 0", if_rvalid);
        end
    endtask

    task automatic test_flush_inflight;
        apply_reset();
        if_req  = 1'b1;
        if_addr = 30'h0;
        next_cycle();
        if_addr = 30'h4;
        next_cycle();
        if_req   = 1'b0;
        if_flush = 1'b1;
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 16'h5CCD) begin
            errors++;
            $display("[TB] FAIL flush_inflight_resp: got rv=%b d=%h expected 1 5ccd", if_rvalid, if_rdata);
        end
        next_cycle();
        if_flush = 1'b0;
        checks++;
        if (if_rvalid !== 1'b0 || if_rdata !== 16'h5CCD) begin
            errors++;
            $display("[TB] FAIL flush_inflight_kill: got rv=%b d=%h expected 0 5ccd", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_flush_data;
        apply_reset();
        dr_req  = 1'b1;
        dr_addr = 30'hA;
        next_cycle();
        dr_req   = 1'b0;
        if_flush = 1'b1;
        next_cycle();
        if_flush = 1'b0;
        checks++;
        if (dr_rvalid !== 1'b1 || dr_rdata !== 16'hB000 || if_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_data: got rv=%b d=%h irv=%b expected 1 b000 0", dr_rvalid, dr_rdata, if_rvalid);
        end
    endtask

    task automatic test_reset_midop;
        logic [67:0] outs;
        apply_reset();
        if_req  = 1'b1;
        if_addr = 30'h4;
        next_cycle();
        if_req = 1'b0;
        rst_n  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            outs = {if_gnt, dr_gnt, if_rvalid, if_err, dr_rvalid, dr_err, if_rdata, dr_rdata, rom_pc};
            checks++;
            if (outs !== '0) begin
                errors++;
                $display("[TB] FAIL midop_reset[%0d]: got %h expected 0", k, outs);
            end
            next_cycle();
        end
        rst_n   = 1'b1;
        if_req  = 1'b1;
        if_addr = 30'hC;
        #1;
        checks++;
        if (if_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midop_first_gnt: got %b expected 1", if_gnt);
        end
        next_cycle();
        if_req = 1'b0;
        checks++;
        if (if_rvalid !== 1'b0 || rom_pc !== 30'hC) begin
            errors++;
            $display("[TB] FAIL midop_stage1: got rv=%b pc=%h expected 0 c", if_rvalid, rom_pc);
        end
        next_cycle();
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 16'hB80E) begin
            errors++;
            $display("[TB] FAIL midop_resp: got rv=%b d=%h expected 1 b80e", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_single_stream;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                dr_req  = 1'b1;
                dr_addr = PC_W'(k * 4);
            end else begin
                dr_req = 1'b0;
            end
            #1;
            if (k < 4) begin
                checks++;
                if (dr_gnt !== 1'b1 || if_gnt !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL stream_gnt[%0d]: got %b%b expected 01", k, if_gnt, dr_gnt);
                end
            end
            if (k >= 2) begin
                checks++;
                if (dr_rvalid !== 1'b1 || dr_rdata !== rom_model(PC_W'((k - 2) * 4))) begin
                    errors++;
                    $display("[TB] FAIL stream_resp[%0d]: got rv=%b d=%h expected 1 %h",
                             k, dr_rvalid, dr_rdata, rom_model(PC_W'((k - 2) * 4)));
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        if_req   = 1'b0;
        dr_req   = 1'b0;
        if_flush = 1'b0;
        if_addr  = '0;
        dr_addr  = '0;
        next_cycle();
        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_misaligned();
        test_flush_new_target();
        test_flush_inflight();
        test_flush_data();
        test_reset_midop();
        test_single_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Shares the single combinational instruction ROM port (`rom_pc` in, 16-bit `rom_instruction` out) between two requesters: the instruction-fetch stage and the data-read path, which handles constant loads from ROM. The block round-robin arbitrates, registers the ROM address, and returns registered 16-bit read data.
- Two-stage pipeline: one grant per cycle, fixed two-cycle latency.
- Halfword alignment check on every request.
- Fetch-flush to kill a stale fetch on a branch.

## Interface
Parameters:
- PC_W, 30, byte-address width; bit 0 is the halfword-alignment bit.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request
- if_addr  in  PC_W  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_flush  in  1  kill fetch access granted in previous cycle
- if_rvalid  out  1  fetch response valid (one-cycle pulse)
- if_rdata  out  16  fetch response data
- if_err  out  1  fetch response is misaligned-address error
- dr_req  in  1  data-read request
- dr_addr  in  PC_W  data-read byte address
- dr_gnt  out  1  data-read accepted this cycle (combinational)
- dr_rvalid  out  1  data-read response valid (pulse)
- dr_rdata  out  16  data-read response data
- dr_err  out  1  data-read misaligned error
- rom_pc  out  PC_W  address to ROM, driven from stage-1 register
- rom_instruction  in  16  ROM data, combinational from rom_pc

## Operation
- Arbitration is combinational on `if_req`, `dr_req`, `last_owner` (1 bit: 0 = fetch, 1 = data).
  - Only one requester active: it is granted.
  - Both active: grant goes to the requester that is not `last_owner`.
  - `last_owner` updates on every grant.
  - Exactly one of `if_gnt` and `dr_gnt` is high, or neither. `gnt` never asserts without the matching `req`.
- Stage 1 (cycle after grant) holds:
  - `s1_valid`, `s1_owner`, `s1_err = addr[0]`.
  - `rom_pc` is loaded with the granted address only on a grant. It otherwise holds, so there is no spurious ROM toggling.
- Stage 2 (cycle after stage 1):
  - The owner's `rvalid` pulses for one cycle.
  - `rdata = s1_err ? 16'h0000 : rom_instruction` sampled at the end of stage 1.
  - `err = s1_err`.
  - The non-owner's `rvalid` and `err` are 0. Its `rdata` holds its last value.
- Misaligned address (bit 0 = 1) is still granted and still occupies a slot. It returns `err=1`, `rdata=0`.
- Flush:
  - `if_flush` high in cycle N clears `s1_valid` if `s1_owner` is fetch. No `if_rvalid` is produced for that access.
  - A fetch granted in cycle N (same cycle as the flush) is not killed. It is the new-target fetch.
  - An `if_rvalid` already asserted in cycle N is still driven; the requester discards it.
  - Flush does not affect a data-read entry.
- No backpressure on responses: requesters must always accept `rvalid`.

## Timing
- Reset values:
  - All outputs 0, `rom_pc = 0`.
  - `last_owner = 1`, so fetch wins the first contention.
  - `s1_valid = 0`.
- Latency: grant in cycle N → `rom_pc` valid in N+1 → `rvalid`/`rdata` in N+2.
- Throughput: one access per cycle total. Back-to-back alternating grants under continuous dual request.
- Reset asserted mid-operation: in-flight stage-1 and stage-2 entries are dropped and no `rvalid` is produced. After `rst_n` deasserts, the first grant can occur in the first clock.
- Single requester continuously requesting with the other idle: granted every cycle.
- PC_W address arithmetic: none. Addresses pass through unmodified; no wrap handling.

## Test plan
- Single fetch, `if_addr=0x0`, ROM returns 16'h5CCD → `if_gnt` in cycle 0, `rom_pc=0` in cycle 1, `if_rvalid=1`, `if_rdata=16'h5CCD`, `if_err=0` in cycle 2. No `dr_rvalid`.
- Both requesting continuously from reset, `if_addr=0x4`, `dr_addr=0xA` → grants alternate F,D,F,D starting with F. Responses alternate from cycle 2 with data 16'h9200 / 16'hB000. No gaps.
- Misaligned data read, `dr_addr=0x3` → `dr_gnt` in cycle 0, `dr_rvalid=1`, `dr_err=1`, `dr_rdata=0` in cycle 2.
- Fetch 0x2 granted in cycle 0; `if_flush` plus new fetch 0xC in cycle 1 → no response for 0x2. Response for 0xC (16'hB80E) in cycle 3.
- Fetch granted in cycle 0; `rst_n` low in cycle 1 → no `if_rvalid` ever. All outputs 0 during reset. Normal grant in the first cycle after release.
- Flush with data read in stage 1 → `dr_rvalid` still delivered with correct data.
